mlp_weight_server: RTL and testbench

//  Responder side of the MLP layer-weight fetch interface. Holds all layer weights in an internal RAM

---
 rtl/mlp_pkg.sv | 25 ++
 rtl/weight_ram.sv | 33 +++
 rtl/mlp_weight_server.sv | 180 ++++++++++++++++++
 tb/tb_mlp_weight_server.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types for the MLP weight server: FSM states, address-width helper
// and the per-layer {base,len} table entry.
package mlp_pkg;

  // Address width for a RAM of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int MLP_DEPTH  = 1024;
  localparam int MLP_ADDR_W = addr_w(MLP_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } weight_srv_state_t;

  // len is one bit wider than base so a layer may span the whole RAM.
  typedef struct packed {
    logic [MLP_ADDR_W-1:0] base;
    logic [MLP_ADDR_W:0]   len;
  } weight_tbl_entry_t;

endpackage

// File: rtl/weight_ram.sv
// Simple dual-port weight RAM: one write port, one enabled read port with
// a single cycle of read latency. A read and a write to the same address in
// the same cycle return the word as it was before the write.
module weight_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Host write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Registered read; holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mlp_weight_server.sv
// MLP layer-weight server: a layer request looks up {base,len} in the table
// and streams RAM[(base+i) mod DEPTH], i = 0..len-1, over a valid/ready
// channel with w_last on the final word.
// Handshake: a word transfers on a rising edge where w_valid && w_ready;
// w_valid never drops and w_data/w_last never change until that transfer.
// Optional feature macro: WEIGHT_PARITY_EN adds per-word even parity and
// the parity_err output.
module mlp_weight_server
  import mlp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUMLAYERBITS = 4,
  parameter int NUM_LAYERS   = 16,
  parameter int DEPTH        = MLP_DEPTH,
  localparam int ADDR_W      = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    cfg_we,
  input  logic [NUMLAYERBITS-1:0] cfg_layer,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [ADDR_W:0]         cfg_len,
  input  logic                    req_valid,
  input  logic [NUMLAYERBITS-1:0] req_layer,
  output logic                    req_ready,
  output logic                    req_err,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [DATA_WIDTH-1:0]   w_data,
  output logic                    w_last,
  output logic                    busy
`ifdef WEIGHT_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam logic [NUMLAYERBITS:0] NL_C = (NUMLAYERBITS+1)'(NUM_LAYERS);
  localparam logic [ADDR_W-1:0]     ADDR_MAX = ADDR_W'(DEPTH - 1);
`ifdef WEIGHT_PARITY_EN
  localparam int RAM_W = DATA_WIDTH + 1;
`else
  localparam int RAM_W = DATA_WIDTH;
`endif

  weight_srv_state_t state_q, state_d;
  weight_tbl_entry_t tbl_q [NUM_LAYERS];
  weight_tbl_entry_t tbl_d [NUM_LAYERS];
  weight_tbl_entry_t req_entry;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
  logic              out_en_q, out_en_d;
  logic              err_q, err_d;
  logic              req_acc, req_in_range, is_last;
  logic              ram_rd_en;
  logic [RAM_W-1:0]  ram_wr_data, ram_rd_data;

`ifdef WEIGHT_PARITY_EN
  logic par_q, par_d, par_mis;
  assign ram_wr_data = {^wr_data, wr_data};
  assign par_mis     = ram_rd_data[DATA_WIDTH] != ^ram_rd_data[DATA_WIDTH-1:0];
`else
  assign ram_wr_data = wr_data;
`endif

  weight_ram #(.WIDTH(RAM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (addr_q),
    .rd_data (ram_rd_data)
  );

  // out_en_q keeps req_ready low until the first clock after reset release.
  assign req_ready    = out_en_q && (state_q == IDLE);
  assign req_acc      = req_valid && req_ready;
  assign req_in_range = {1'b0, req_layer} < NL_C;
  assign req_entry    = req_in_range ? tbl_q[req_layer] : '0;
  assign addr_inc     = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
  assign is_last      = cnt_q == (len_q - (ADDR_W+1)'(1));
  assign w_valid      = state_q == STREAM;
  assign w_last       = w_valid && is_last;
  assign w_data       = w_valid ? ram_rd_data[DATA_WIDTH-1:0] : '0;
  assign busy         = state_q != IDLE;
  assign req_err      = err_q;

  // Layer table update; out-of-range entries are dropped.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we && ({1'b0, cfg_layer} < NL_C)) begin
      tbl_d[cfg_layer] = '{base: cfg_base, len: cfg_len};
    end
  end

  // Next state, read-address generation and word counting.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    out_en_d  = 1'b1;
    ram_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_acc) begin
          if (req_in_range && (req_entry.len != '0)) begin
            state_d = FETCH;
            addr_d  = req_entry.base;
            len_d   = req_entry.len;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        ram_rd_en = 1'b1;
        addr_d    = addr_inc;
        state_d   = STREAM;
      end
      STREAM: begin
        if (w_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            ram_rd_en = 1'b1;
            addr_d    = addr_inc;
            cnt_d     = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WEIGHT_PARITY_EN
  // Sticky parity flag, cleared by the next accepted request.
  always_comb begin
    par_d = par_q;
    if (req_acc) par_d = 1'b0;
    else if (w_valid && par_mis) par_d = 1'b1;
  end

  assign parity_err = par_q || (w_valid && par_mis);

  // Parity flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  // State, table and stream registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tbl_q    <= '{default: '0};
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      out_en_q <= out_en_d;
    end
  end

endmodule

// File: tb/tb_mlp_weight_server.sv
// Bench for mlp_weight_server: a reference model (RAM array + layer table)
// pushes expected {last,data} words at request accept; a negedge monitor
// pops and compares on every handshake. Build with WEIGHT_PARITY_EN to
// exercise the parity port as well.
module tb_mlp_weight_server;

  localparam int DW    = 32;
  localparam int LB    = 4;
  localparam int NL    = 12;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk, reset;
  logic          wr_en, cfg_we, req_valid, w_ready;
  logic [AW-1:0] wr_addr, cfg_base;
  logic [DW-1:0] wr_data, w_data;
  logic [LB-1:0] cfg_layer, req_layer;
  logic [AW:0]   cfg_len;
  logic          req_ready, req_err, w_valid, w_last, busy;
`ifdef WEIGHT_PARITY_EN
  logic          parity_err;
`endif

  mlp_weight_server #(
    .DATA_WIDTH(DW), .NUMLAYERBITS(LB), .NUM_LAYERS(NL), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .req_valid(req_valid), .req_layer(req_layer), .req_ready(req_ready), .req_err(req_err),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last), .busy(busy)
`ifdef WEIGHT_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model & scoreboard ----------------
  logic [DW-1:0] ram_m  [DEPTH];
  int            base_m [NL];
  int            len_m  [NL];
  logic [DW:0]   exp_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            hs_count = 0;
  logic          err_expect = 1'b0;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_write(input int addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    ram_m[addr] = data;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom;
      ram_m[i] = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cfg_write(input int layer, input int base, input int len);
    @(negedge clk);
    cfg_we = 1'b1; cfg_layer = LB'(layer); cfg_base = AW'(base); cfg_len = (AW+1)'(len);
    @(negedge clk);
    cfg_we = 1'b0;
    if (layer < NL) begin
      base_m[layer] = base;
      len_m[layer]  = len;
    end
  endtask

  task automatic do_req(input int layer);
    int  budget;
    bit  good;
    budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    chk("req_ready_wait", req_ready, 1);
    if (req_ready) begin
      req_valid = 1'b1; req_layer = LB'(layer);
      @(posedge clk);
      good = (layer < NL) && (len_m[layer] != 0);
      if (good) begin
        for (int i = 0; i < len_m[layer]; i++)
          exp_q.push_back({i == len_m[layer] - 1, ram_m[(base_m[layer] + i) % DEPTH]});
        @(negedge clk);
        req_valid = 1'b0;
        chk("lat_fetch_valid", w_valid, 0);
        chk("lat_fetch_busy", busy, 1);
        @(negedge clk);
        chk("lat_first_valid", w_valid, 1);
      end else begin
        err_expect = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("err_busy", busy, 0);
        chk("err_no_valid", w_valid, 0);
        @(posedge clk);
        err_expect = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || exp_q.size() != 0) && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("stream_done", {busy, 31'(exp_q.size())}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_w_last"}, w_last, 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_err"}, req_err, 0);
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    int pat;
    pat = 0;
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       w_ready = 1'($urandom_range(0, 1));
        2:       begin w_ready = (pat % 3) == 0; pat++; end
        default: w_ready = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        stall_pend;
    logic [DW:0] stall_val, exp;
    stall_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_pend = 1'b0;
      end else begin
        chk("req_err", req_err, err_expect);
        if (w_valid) begin
          if (stall_pend) chk("stall_hold", {w_last, w_data}, stall_val);
`ifdef WEIGHT_PARITY_EN
          chk("parity_err", parity_err, 0);
`endif
          if (w_ready) begin
            hs_count++;
            chk("w_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              exp = exp_q.pop_front();
              chk("w_word", {w_last, w_data}, exp);
            end
            stall_pend = 1'b0;
          end else begin
            stall_pend = 1'b1;
            stall_val  = {w_last, w_data};
          end
        end else begin
          stall_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int hs0;
    reset = 1'b1; wr_en = 1'b0; cfg_we = 1'b0; req_valid = 1'b0;
    wr_addr = '0; wr_data = '0; cfg_layer = '0; cfg_base = '0; cfg_len = '0; req_layer = '0;
    for (int i = 0; i < NL; i++) begin base_m[i] = 0; len_m[i] = 0; end
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rdy_release_low", req_ready, 0);
    @(posedge clk);
    #1 chk("rdy_release_high", req_ready, 1);

    fill_ram();
    host_write(0, 32'hA0A0_0001);
    host_write(1, 32'hB0B0_0002);
    host_write(2, 32'hC0C0_0003);
    host_write(3, 32'hD0D0_0004);
    cfg_write(0, 0, 4);
    cfg_write(2, DEPTH - 2, 4);

    // basic stream, consumer always ready
    rdy_mode = 0;
    do_req(0);
    wait_idle();

    // consumer stalls 1,0,0,... : still exactly four transfers
    rdy_mode = 2;
    hs0 = hs_count;
    do_req(0);
    wait_idle();
    chk("stall_handshakes", hs_count - hs0, 4);

    // address wrap at the top of the RAM
    rdy_mode = 0;
    do_req(2);
    wait_idle();

    // error cases: layer out of range, zero length, ignored cfg slot
    do_req(NL);
    cfg_write(5, 7, 0);
    do_req(5);
    cfg_write(13, 9, 3);
    do_req(13);
    chk("err_idle_busy", busy, 0);

    // back-to-back requests
    do_req(0);
    do_req(2);
    wait_idle();

    // randomized traffic
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        host_write($urandom_range(0, DEPTH - 1), $urandom);
      end
      if ($urandom_range(0, 1) == 0)
        cfg_write($urandom_range(0, 15), $urandom_range(0, DEPTH - 1), $urandom_range(0, 10));
      do_req($urandom_range(0, 15));
    end
    wait_idle();

    // reset in the middle of a stream
    rdy_mode = 0;
    cfg_write(1, 100, 8);
    do_req(1);
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin base_m[i] = 0; len_m[i] = 0; end
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("midrst_rdy_low", req_ready, 0);
    @(posedge clk);
    #1 chk("midrst_rdy_high", req_ready, 1);

    // table was cleared; RAM contents survive
    do_req(0);
    cfg_write(0, 0, 4);
    do_req(0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
